// File: rtl/nn_host_channel_responder.sv
// nn_host_channel_responder
// Host-side partner of the generated neural-network top. It holds the input
// vector and serves the network's fill reads from it. It captures the network's
// drain writes into a result RAM. It sequences one inference at a time:
// IDLE -> CLR -> FILL -> RUN -> DONE -> IDLE.
// Optional feature: define NN_WATCHDOG_EN to bound the FILL and RUN waits to
// TIMEOUT_CYC cycles (expiry sets err and finishes the inference with done).
module nn_host_channel_responder #(
    parameter int DATA_W      = 8,
    parameter int N_IN        = 2,
    parameter int N_OUT       = 1,
    parameter int TIMEOUT_CYC = 1024,
    localparam int IN_AW  = ($clog2(N_IN)  > 1) ? $clog2(N_IN)  : 1,
    localparam int OUT_AW = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_wr,
    input  logic [IN_AW-1:0]  host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              start,
    input  logic [OUT_AW-1:0] res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              net_rst,
    output logic              net_fill,
    input  logic              net_ack_fill,
    output logic              net_req,
    input  logic              net_ack_network,
    input  logic              net_rd_trig,
    input  logic [IN_AW-1:0]  net_rd_addr,
    output logic [DATA_W-1:0] net_rd_data,
    input  logic              net_wr_trig,
    input  logic [OUT_AW-1:0] net_wr_addr,
    input  logic [DATA_W-1:0] net_wr_data
);

    // RAMs are sized to the full address space so every index is legal.
    // Entries at or beyond N_IN / N_OUT are never written or read by the network.
    localparam int IN_DEPTH  = 1 << IN_AW;
    localparam int OUT_DEPTH = 1 << OUT_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;

    logic signed [DATA_W-1:0] in_ram  [IN_DEPTH];
    logic signed [DATA_W-1:0] out_ram [OUT_DEPTH];

    logic host_oor;
    logic rd_oor;
    logic wr_oor;
    logic wd_hit;

    assign host_oor = 32'(host_waddr)  >= N_IN;
    assign rd_oor   = 32'(net_rd_addr) >= N_IN;
    assign wr_oor   = 32'(net_wr_addr) >= N_OUT;

    assign res_data = out_ram[res_addr];

`ifdef NN_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    logic [WD_W-1:0] wd_cnt;

    assign wd_hit = ((state == S_FILL) || (state == S_RUN)) &&
                    (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: counts cycles spent waiting in FILL or RUN; any other cycle or a state change restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if ((state == S_FILL && !net_ack_fill) ||
                     (state == S_RUN  && !net_ack_network)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Host loads the input vector only while no inference is in flight.
    always_ff @(posedge clk) begin
        if (host_wr && (state == S_IDLE) && !host_oor) begin
            in_ram[host_waddr] <= host_wdata;
        end
    end

    // Network drain writes are captured only while the network is running.
    always_ff @(posedge clk) begin
        if (net_wr_trig && (state == S_RUN) && !wr_oor) begin
            out_ram[net_wr_addr] <= net_wr_data;
        end
    end

    // Inference sequencer, registered handshake outputs, read response and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            net_rst     <= 1'b0;
            net_fill    <= 1'b0;
            net_req     <= 1'b0;
            net_rd_data <= '0;
        end else begin
            done    <= 1'b0;
            net_rst <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_CLR;
                        busy    <= 1'b1;
                        net_rst <= 1'b1;
                        err     <= 1'b0;
                    end
                end
                // One clear cycle gives the network time to drop any ack level left from the last run.
                S_CLR: begin
                    state    <= S_FILL;
                    net_fill <= 1'b1;
                end
                S_FILL: begin
                    if (net_ack_fill) begin
                        state    <= S_RUN;
                        net_fill <= 1'b0;
                        net_req  <= 1'b1;
                    end else if (wd_hit) begin
                        state    <= S_DONE;
                        net_fill <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (net_ack_network) begin
                        state   <= S_DONE;
                        net_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (wd_hit) begin
                        state   <= S_DONE;
                        net_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Error sets come last so that they win over the clear on start.
            if (net_rd_trig) begin
                if (rd_oor) begin
                    net_rd_data <= '0;
                    err         <= 1'b1;
                end else begin
                    net_rd_data <= in_ram[net_rd_addr];
                end
            end
            if (net_wr_trig && (state == S_RUN) && wr_oor) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nn_host_channel_responder.sv
// Testbench for nn_host_channel_responder. The instance uses N_IN=3 so that an
// out-of-range read address is representable on the 2-bit read port, and
// TIMEOUT_CYC=16 for the watchdog scenario (active only with NN_WATCHDOG_EN).
module tb_nn_host_channel_responder;

    localparam int DATA_W      = 8;
    localparam int N_IN        = 3;
    localparam int N_OUT       = 1;
    localparam int TIMEOUT_CYC = 16;
    localparam int IN_AW       = 2;
    localparam int OUT_AW      = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              host_wr = 1'b0;
    logic [IN_AW-1:0]  host_waddr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              start = 1'b0;
    logic [OUT_AW-1:0] res_addr = '0;
    logic [DATA_W-1:0] res_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              net_rst;
    logic              net_fill;
    logic              net_ack_fill = 1'b0;
    logic              net_req;
    logic              net_ack_network = 1'b0;
    logic              net_rd_trig = 1'b0;
    logic [IN_AW-1:0]  net_rd_addr = '0;
    logic [DATA_W-1:0] net_rd_data;
    logic              net_wr_trig = 1'b0;
    logic [OUT_AW-1:0] net_wr_addr = '0;
    logic [DATA_W-1:0] net_wr_data = '0;

    nn_host_channel_responder #(
        .DATA_W      (DATA_W),
        .N_IN        (N_IN),
        .N_OUT       (N_OUT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .host_wr         (host_wr),
        .host_waddr      (host_waddr),
        .host_wdata      (host_wdata),
        .start           (start),
        .res_addr        (res_addr),
        .res_data        (res_data),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .net_rst         (net_rst),
        .net_fill        (net_fill),
        .net_ack_fill    (net_ack_fill),
        .net_req         (net_req),
        .net_ack_network (net_ack_network),
        .net_rd_trig     (net_rd_trig),
        .net_rd_addr     (net_rd_addr),
        .net_rd_data     (net_rd_data),
        .net_wr_trig     (net_wr_trig),
        .net_wr_addr     (net_wr_addr),
        .net_wr_data     (net_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_AW-1:0] a;
        logic [DATA_W-1:0] d;
    } res_t;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [DATA_W-1:0] rd_q [$];
    res_t              res_q [$];
    logic [DATA_W-1:0] last_res = '0;

    // Count done pulses on the falling edge, away from the active edge.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [IN_AW-1:0] a, input logic [DATA_W-1:0] d);
        host_wr = 1'b1; host_waddr = a; host_wdata = d;
        tick();
        host_wr = 1'b0;
    endtask

    // Issue one read strobe and queue the value expected one cycle later.
    task automatic rd_strobe(input logic [IN_AW-1:0] a, input logic [DATA_W-1:0] e);
        rd_q.push_back(e);
        net_rd_trig = 1'b1; net_rd_addr = a;
        tick();
        net_rd_trig = 1'b0;
    endtask

    // Issue one write strobe; queue the result only when it must be captured.
    task automatic wr_strobe(input logic [OUT_AW-1:0] a, input logic [DATA_W-1:0] d, input bit capture);
        res_t r;
        if (capture) begin
            r.a = a; r.d = d;
            res_q.push_back(r);
            last_res = d;
        end
        net_wr_trig = 1'b1; net_wr_addr = a; net_wr_data = d;
        tick();
        net_wr_trig = 1'b0;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] e;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, err, net_rst, net_fill, net_req} !== 6'b0 || net_rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_init: busy/done/err/rst/fill/req=%b rd=%h, required 000000 00",
                     {busy, done, err, net_rst, net_fill, net_req}, net_rd_data);
        end
        host_write(0, 8'h5A);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        rd_strobe(0, 8'h5A);
        e = rd_q.pop_front();
        checks++;
        if (net_fill !== 1'b1 || busy !== 1'b1 || net_rd_data !== e) begin
            failures++;
            $display("FAIL reset_pre: fill=%b busy=%b rd=%h, required 1 1 %h", net_fill, busy, net_rd_data, e);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, net_rst, net_fill, net_req} !== 6'b0 || net_rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_async: busy/done/err/rst/fill/req=%b rd=%h, required 000000 00",
                     {busy, done, err, net_rst, net_fill, net_req}, net_rd_data);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || net_fill !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b fill=%b, required 0 0", busy, net_fill);
        end
    endtask

    task automatic test_fill_read();
        logic [DATA_W-1:0] e;
        host_write(0, 8'h11);
        host_write(1, 8'hEF);
        host_write(2, 8'h05);
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (net_rst !== 1'b1 || busy !== 1'b1 || net_fill !== 1'b0) begin
            failures++;
            $display("FAIL clr_entry: net_rst=%b busy=%b fill=%b, required 1 1 0", net_rst, busy, net_fill);
        end
        tick();
        checks++;
        if (net_rst !== 1'b0 || net_fill !== 1'b1 || net_req !== 1'b0) begin
            failures++;
            $display("FAIL fill_entry: net_rst=%b fill=%b req=%b, required 0 1 0", net_rst, net_fill, net_req);
        end
        for (int i = 0; i < 3; i++) begin
            logic [DATA_W-1:0] v;
            v = (i == 0) ? 8'h11 : (i == 1) ? 8'hEF : 8'h05;
            rd_strobe(IN_AW'(i), v);
            e = rd_q.pop_front();
            checks++;
            if (net_rd_data !== e) begin
                failures++;
                $display("FAIL rd_data addr=%0d: got %h, required %h", i, net_rd_data, e);
            end
        end
        tick();
        checks++;
        if (net_rd_data !== 8'h05) begin
            failures++;
            $display("FAIL rd_hold: got %h, required 05", net_rd_data);
        end
        net_ack_fill = 1'b1; tick(); net_ack_fill = 1'b0;
        checks++;
        if (net_fill !== 1'b0 || net_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL run_entry: fill=%b req=%b busy=%b, required 0 1 1", net_fill, net_req, busy);
        end
    endtask

    task automatic test_capture();
        int n0;
        res_t r;
        wr_strobe(0, 8'h7F, 1'b1);
        n0 = done_cnt;
        net_ack_network = 1'b1; tick(); net_ack_network = 0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || net_req !== 1'b0) begin
            failures++;
            $display("FAIL done_rise: done=%b busy=%b req=%b, required 1 0 0", done, busy, net_req);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_fall: done=%b busy=%b, required 0 0", done, busy);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt - n0 != 1) begin
            failures++;
            $display("FAIL done_once: pulses=%0d, required 1", done_cnt - n0);
        end
        while (res_q.size() > 0) begin
            r = res_q.pop_front();
            res_addr = r.a;
            #1;
            checks++;
            if (res_data !== r.d) begin
                failures++;
                $display("FAIL res_data addr=%0d: got %h, required %h", r.a, res_data, r.d);
            end
        end
    endtask

    task automatic test_oor();
        logic [DATA_W-1:0] e;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        rd_strobe(3, 8'h00);
        e = rd_q.pop_front();
        checks++;
        if (net_rd_data !== e || err !== 1'b1) begin
            failures++;
            $display("FAIL rd_oor: rd=%h err=%b, required %h 1", net_rd_data, err, e);
        end
        net_ack_fill = 1'b1; tick(); net_ack_fill = 1'b0;
        net_ack_network = 1'b1; tick(); net_ack_network = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL oor_done: done=%b err=%b, required 1 1", done, err);
        end
        tick();
    endtask

    task automatic test_ignored();
        logic [DATA_W-1:0] e;
        res_t r;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (err !== 1'b0 || net_rst !== 1'b1) begin
            failures++;
            $display("FAIL err_cleared: err=%b net_rst=%b, required 0 1", err, net_rst);
        end
        tick();
        host_write(0, 8'h55);
        wr_strobe(0, 8'h22, 1'b0);
        rd_strobe(0, 8'h11);
        e = rd_q.pop_front();
        checks++;
        if (net_rd_data !== e) begin
            failures++;
            $display("FAIL host_wr_dropped: rd=%h, required %h", net_rd_data, e);
        end
        res_addr = 0;
        #1;
        checks++;
        if (res_data !== last_res) begin
            failures++;
            $display("FAIL wr_fill_ignored: res=%h, required %h", res_data, last_res);
        end
        net_ack_fill = 1'b1; tick(); net_ack_fill = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (net_req !== 1'b1 || busy !== 1'b1 || net_rst !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL start_in_run: req=%b busy=%b net_rst=%b err=%b, required 1 1 0 0",
                     net_req, busy, net_rst, err);
        end
        wr_strobe(1, 8'h33, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL wr_oor_err: err=%b, required 1", err);
        end
        wr_strobe(0, 8'h80, 1'b1);
        net_ack_network = 1'b1; tick(); net_ack_network = 1'b0;
        tick();
        while (res_q.size() > 0) begin
            r = res_q.pop_front();
            res_addr = r.a;
            #1;
            checks++;
            if (res_data !== r.d) begin
                failures++;
                $display("FAIL res_neg addr=%0d: got %h, required %h", r.a, res_data, r.d);
            end
        end
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || net_rst !== 1'b0) begin
            failures++;
            $display("FAIL no_restart: busy=%b net_rst=%b, required 0 0", busy, net_rst);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        net_ack_fill = 1'b1; tick(); net_ack_fill = 1'b0;
        net_ack_network = 1'b1; tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: done=%b, required 1", done);
        end
        start = 1'b1; tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || net_rst !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: done=%b busy=%b net_rst=%b, required 0 0 0", done, busy, net_rst);
        end
        tick(); start = 1'b0;
        checks++;
        if (net_rst !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: net_rst=%b busy=%b, required 1 1", net_rst, busy);
        end
        repeat (2) tick();
        checks++;
        if (net_fill !== 1'b1 || net_req !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL stale_ack_masked: fill=%b req=%b done=%b, required 1 0 0", net_fill, net_req, done);
        end
        net_ack_network = 1'b0;
        net_ack_fill = 1'b1; tick(); net_ack_fill = 1'b0;
        net_ack_network = 1'b1; tick(); net_ack_network = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_done: done=%b busy=%b, required 1 0", done, busy);
        end
        tick();
    endtask

    task automatic test_watchdog();
        int bad;
        bad = 0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
`ifdef NN_WATCHDOG_EN
        repeat (TIMEOUT_CYC - 1) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wd_no_early: early cycles=%0d, required 0", bad);
        end
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || net_fill !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_timeout: done=%b err=%b fill=%b busy=%b, required 1 1 0 0",
                     done, err, net_fill, busy);
        end
        tick();
        start = 1'b1; tick(); start = 1'b0;
        tick();
`else
        repeat (40) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0 || net_fill !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL no_wd_wait: cycles left FILL=%0d, required 0", bad);
        end
`endif
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || net_fill !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort: busy=%b fill=%b, required 0 0", busy, net_fill);
        end
        tick();
        rst = 1'b0;
        tick();
        res_addr = 0;
        #1;
        checks++;
        if (res_data !== last_res) begin
            failures++;
            $display("FAIL rst_keeps_results: res=%h, required %h", res_data, last_res);
        end
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_capture();
        test_oor();
        test_ignored();
        test_back_to_back();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
